// File: rtl/sync_fifo_ctrl.sv
`timescale 1ns/1ps
// sync_fifo_ctrl
//   Single-clock FIFO controller with an internal storage array and a registered
//   read port (read latency 1). It provides fill-level and threshold flags, and
//   sticky overflow/underflow indicators.
//
// Parameters
//   DATA_WIDTH    : width of each stored word
//   ADDR_WIDTH    : address width, DEPTH = 2**ADDR_WIDTH
//   AFULL_THRESH  : almost_full when count >= AFULL_THRESH
//   AEMPTY_THRESH : almost_empty when count <= AEMPTY_THRESH
//
// Ports
//   clk          : clock, all logic on posedge
//   rst          : asynchronous active-high reset
//   flush        : synchronous clear of pointers, count, flags and rd_valid
//   wr_en        : write request
//   wr_data      : write word
//   rd_en        : read request
//   rd_data      : registered read word
//   rd_valid     : rd_data updated this cycle
//   full / empty : count == DEPTH / count == 0
//   almost_full  : threshold flag
//   almost_empty : threshold flag
//   count        : fill level, 0..DEPTH
//   overflow     : sticky, write attempted while full
//   underflow    : sticky, read attempted while empty
module sync_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH    = 41,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic wr_accept;
   logic rd_accept;

   // Flags come only from the registered count, so they are glitch-free
   // relative to the request inputs.
   always_comb begin
      full         = (count_q == (ADDR_WIDTH+1)'(DEPTH));
      empty        = (count_q == '0);
      almost_full  = (count_q >= (ADDR_WIDTH+1)'(AFULL_THRESH));
      almost_empty = (count_q <= (ADDR_WIDTH+1)'(AEMPTY_THRESH));
   end

   assign wr_accept = wr_en & ~full & ~flush;
   assign rd_accept = rd_en & ~empty & ~flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (flush) begin
         // rd_data and the storage array are intentionally left as they are.
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
         end
         if (wr_en && full) begin
            overflow_d = 1'b1;
         end
         if (rd_en && empty) begin
            underflow_d = 1'b1;
         end
         case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; the read of mem[rd_ptr_q] above sees the old contents,
   // so a same-cycle write never shows up on the read port.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
`timescale 1ns/1ps
// tb_sync_fifo_ctrl
//   Self-checking bench for sync_fifo_ctrl (DEPTH=16, DATA_WIDTH=41). A reference
//   model tracks stored words, count and sticky flags. Words leaving the model on
//   an accepted read go into a scoreboard queue and are compared when rd_valid
//   is expected.
module tb_sync_fifo_ctrl;

   localparam int DW    = 41;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   sync_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state
   logic [DW-1:0] m_store[$];
   logic [DW-1:0] sb[$];
   int            m_cnt  = 0;
   logic          m_ovf  = 1'b0;
   logic          m_unf  = 1'b0;
   logic          m_vld  = 1'b0;
   logic [DW-1:0] m_last = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_status();
      check("count", 64'(count), 64'(m_cnt));
      check("full", 64'(full), 64'(m_cnt == DEPTH));
      check("empty", 64'(empty), 64'(m_cnt == 0));
      check("almost_full", 64'(almost_full), 64'(m_cnt >= DEPTH - 2));
      check("almost_empty", 64'(almost_empty), 64'(m_cnt <= 2));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underflow", 64'(underflow), 64'(m_unf));
   endtask

   // One clock cycle: drive, update model, step past the edge, compare.
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
      logic acc_w;
      logic acc_r;
      logic [DW-1:0] e;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      flush   = f;
      acc_w = w && (m_cnt != DEPTH) && !f;
      acc_r = r && (m_cnt != 0) && !f;
      if (f) begin
         m_store.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && m_cnt == DEPTH) m_ovf = 1'b1;
         if (r && m_cnt == 0)     m_unf = 1'b1;
         if (acc_r) begin
            sb.push_back(m_store.pop_front());
            m_cnt--;
         end
         if (acc_w) begin
            m_store.push_back(d);
            m_cnt++;
         end
      end
      m_vld = acc_r;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
      check("rd_valid", 64'(rd_valid), 64'(m_vld));
      if (m_vld) begin
         if (sb.size() == 0) begin
            check("sb_underrun", 64'(0), 64'(1));
         end else begin
            e = sb.pop_front();
            check("rd_data", 64'(rd_data), 64'(e));
            m_last = e;
         end
      end else begin
         check("rd_hold", 64'(rd_data), 64'(m_last));
      end
      check_status();
   endtask

   logic [DW-1:0] dv;

   initial begin
      rst     = 1'b1;
      flush   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      rd_en   = 1'b0;
      #1;
      check("rst_rd_data", 64'(rd_data), 64'(0));
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check_status();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill 0x001..0x010, one extra write would overflow but is not issued here.
      for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
      // Drain in order.
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

      // 20 writes, last four dropped; drain; one extra read underflows.
      for (int i = 1; i <= 20; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Fill to 8, then 40 cycles of simultaneous read/write across the wrap.
      dv = DW'(41'h1_0000_0000);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, dv, 1'b0, 1'b0);
         dv++;
      end
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, dv, 1'b1, 1'b0);
         dv++;
      end
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Simultaneous wr/rd while empty, and while full.
      cycle(1'b1, DW'(32'h55), 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) cycle(1'b1, DW'(32'h60 + i), 1'b0, 1'b0);
      cycle(1'b1, DW'(32'h77), 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Set both sticky flags, settle at count 5, flush with a write pending.
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) cycle(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, DW'(41'h0_dead_beef), 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, DW'(32'h3ab), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Fill to 9, then assert reset between edges.
      for (int i = 0; i < 9; i++) cycle(1'b1, DW'(32'h400 + i), 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      m_store.delete();
      sb.delete();
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_last = '0;
      check("async_rd_data", 64'(rd_data), 64'(0));
      check("async_rd_valid", 64'(rd_valid), 64'(0));
      check_status();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Stored words are gone: a read needs a fresh write.
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, DW'(32'h5a5), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 41: width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width, DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= AEMPTY_THRESH.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_WIDTH  registered read word.
- rd_valid  out  1  rd_data updated this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- count  out  ADDR_WIDTH+1  current fill level, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Function
REQ-006 SHALL store words in an internal DEPTH x DATA_WIDTH array; read and write SHALL share clk.
REQ-007 SHALL accept a write iff wr_en=1, full=0 and flush=0; accepted word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-008 SHALL accept a read iff rd_en=1, empty=0 and flush=0; rd_ptr increments modulo DEPTH.
REQ-009 SHALL register mem[rd_ptr] into rd_data on the edge accepting the read; rd_valid=1 for exactly the following cycle (read latency 1).
REQ-010 SHALL hold rd_data unchanged and drive rd_valid=0 in any cycle following no accepted read.
REQ-011 SHALL update count by +1 (write only), -1 (read only), 0 (both or neither accepted) on each edge.
REQ-012 SHALL derive full, empty, almost_full, almost_empty combinationally from registered count only.
REQ-013 Simultaneous wr_en and rd_en while empty: write accepted, read rejected, underflow set, count 0->1.
REQ-014 Simultaneous wr_en and rd_en while full: read accepted, write rejected, overflow set, count DEPTH->DEPTH-1.
REQ-015 Simultaneous accepted read and write at 0<count<DEPTH: both performed, count unchanged; read returns the oldest word, never the word written that cycle.
REQ-016 SHALL set overflow on any edge with wr_en=1, full=1, flush=0; set underflow on any edge with rd_en=1, empty=1, flush=0; both remain set until flush or rst.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of data.
REQ-018 flush=1 SHALL on the next edge clear wr_ptr, rd_ptr, count, overflow, underflow, rd_valid; wr_en/rd_en that cycle SHALL be ignored; rd_data and memory contents retained.

Reset
REQ-019 rst=1 SHALL immediately, regardless of clk, force wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-020 Reset asserted mid-operation SHALL discard all stored words; the first read after reset deassertion SHALL require a fresh write.
REQ-021 Memory array SHALL not be reset.

Verification (DEPTH=16, DATA_WIDTH=41, thresholds default)
REQ-022 Write 0x001..0x010 back-to-back -> full=1 after 16th edge, almost_full=1 from count=14, count=16, overflow=0.
REQ-023 From full, read 16 times -> rd_data 0x001..0x010 in order, each one cycle after its rd_en, rd_valid high 16 cycles, empty=1, almost_empty=1 from count=2.
REQ-024 Write 20 words with no reads, then rd_en on empty -> words 17-20 dropped, overflow=1; final extra rd_en sets underflow=1.
REQ-025 Fill to 8, then 40 cycles simultaneous wr/rd with incrementing data -> count stays 8, read sequence continuous across pointer wrap.
REQ-026 Fill to 5, set flags via over/underflow, pulse flush with wr_en=1 -> count=0, flags cleared, written word not stored.
REQ-027 Assert rst asynchronously between edges with count=9 -> count=0, rd_data=0, empty=1 before next edge.
